iter_shift_ctrl: RTL and testbench

//   Multi-cycle shift sequencer for the ALU shift instructions (SLL/SRL/SRA).
//   It reuses one fixed shift-by-2 step and one shift-by-1 step each cycle,
//   so no full barrel shifter is needed. It accepts one request at a time

---
 rtl/iter_shift_ctrl.sv | 131 +++++++++++++
 tb/tb_iter_shift_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_ctrl.sv
// Iterative SLL/SRL/SRA sequencer: shifts by 2 or by 1 per cycle under a start/done handshake.
// Optional abort input enabled by defining ITER_SHIFT_ABORT_EN.
module iter_shift_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
`ifdef ITER_SHIFT_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    localparam logic [SHW-1:0] CntOne = SHW'(1);
    localparam logic [SHW-1:0] CntTwo = SHW'(2);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             step2;
    logic [WIDTH-1:0] acc_step;
    logic [SHW-1:0]   cnt_step;
    logic             abort_in;
    logic             abort_hit;
    logic             start_ok;

`ifdef ITER_SHIFT_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    // Abort only matters while an operation is in flight; it also blocks a new accept.
    assign abort_hit = abort_in && (state_q != StIdle);
    assign start_ok  = start && !abort_in;

    // One shift step: by 2 while at least two positions remain, otherwise by 1.
    always_comb begin
        step2    = (cnt_q >= CntTwo);
        cnt_step = cnt_q - (step2 ? CntTwo : CntOne);
        acc_step = acc_q;
        case (op_q)
            OpSll:   acc_step = step2 ? (acc_q << 2) : (acc_q << 1);
            OpSrl:   acc_step = step2 ? (acc_q >> 2) : (acc_q >> 1);
            OpSra:   acc_step = step2 ? ($signed(acc_q) >>> 2) : ($signed(acc_q) >>> 1);
            default: acc_step = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OpSll;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        acc_q  <= data_in;
                        cnt_q  <= shamt;
                        op_q   <= op;
                        busy_q <= 1'b1;
                        if (shamt == '0 || op == OpPass) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= data_in;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    if (abort_hit) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_step;
                        // Result is loaded on the way into DONE so it is valid with the pulse.
                        if (cnt_step == '0) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= acc_step;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q && !abort_hit;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Scoreboard bench for iter_shift_ctrl: driver pushes expected result/cycle, monitor pops on done.
module tb_iter_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    iter_shift_ctrl #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .data_in(data_in),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [31:0] exp_held = '0;
    bit          mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: the architectural meaning of each op, not the stepwise datapath.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input int sh);
        case (o)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return $signed(d) >>> sh;
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("result", result, e.res);
                    exp_held = e.res;
                end
            end else begin
                check("result_hold", result, exp_held);
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_done at cycle %0d: got no done expected by cycle %0d",
                             cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        exp_t e;
        int   lat;
        @(negedge clk);
        op      = o;
        data_in = d;
        shamt   = s;
        start   = 1'b1;
        lat     = (o == 2'b11) ? 0 : (int'(s) + 1) / 2;
        e.res   = ref_shift(o, d, int'(s));
        e.cyc   = cyc + 1 + lat;
        sb.push_back(e);
        busy_lo = cyc + 1;
        busy_hi = cyc + 1 + lat;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = $urandom;
        shamt   = 5'($urandom);
    endtask

    // Wait out the operation, optionally firing ignored starts, then idle 0..maxgap cycles.
    task automatic finish_op(input bit noisy, input int maxgap);
        int guard = 0;
        while (cyc < busy_hi) begin
            @(negedge clk);
            if (noisy) begin
                start   = ($urandom_range(0, 3) == 0);
                op      = 2'($urandom);
                data_in = $urandom;
                shamt   = 5'($urandom);
            end
            guard++;
            if (guard > 40) begin
                checks++;
                errors++;
                $display("FAIL op_timeout at cycle %0d: got busy window open expected closed", cyc);
                break;
            end
        end
        repeat ($urandom_range(0, maxgap)) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        issue(2'b00, 32'h0000_0001, 5'd31);
        finish_op(0, 0);
        issue(2'b10, 32'h8000_0000, 5'd4);
        finish_op(0, 1);
        issue(2'b01, 32'h8000_0000, 5'd4);
        finish_op(0, 1);
        issue(2'b01, 32'h8000_0000, 5'd3);
        finish_op(0, 1);
        issue(2'b00, 32'hDEAD_BEEF, 5'd0);
        finish_op(0, 1);
        issue(2'b11, 32'hDEAD_BEEF, 5'd7);
        finish_op(0, 1);

        // Start pulse while busy must be ignored; next request right after done is accepted.
        issue(2'b00, 32'h1234_5678, 5'd20);
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b01;
        data_in = 32'hFFFF_0000;
        shamt   = 5'd1;
        @(negedge clk);
        start   = 1'b0;
        finish_op(0, 0);
        issue(2'b10, 32'hF000_000F, 5'd9);
        finish_op(1, 0);

        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom), $urandom, 5'($urandom));
            finish_op(1, 2);
        end

        // Reset mid-operation: everything returns to zero and no done follows.
        issue(2'b00, 32'hA5A5_A5A5, 5'd31);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        exp_held = '0;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom), $urandom, 5'($urandom));
            finish_op(1, 2);
        end

        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
